tage_bank: RTL and testbench

- Parametrised next-generation TAGE tagged component: prediction counter, partial tag and useful counter per entry.
- Fixes widths, depth and reset period through parameters.
- Splits lookup and update onto independent explicitly-indexed ports, bypasses same-cycle updates onto lookups, and replaces the one-shot useful clear with a paced background sweep.
- One instance per history length inside the TAGE predictor top; the provider/alternate selection logic consumes its lookup outputs and drives its update port.

---
 rtl/tage_pkg.sv | 36 +++
 rtl/tage_bank_entry_upd.sv | 66 ++++++
 rtl/tage_bank.sv | 209 ++++++++++++++++++++
 tb/tb_tage_bank.sv | 368 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tage_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : tage_pkg
//  Brief    : Shared state encoding and saturating-counter helpers for the
//             TAGE tagged bank.
//  Revision : 1.0 - initial release
// ============================================================================
package tage_pkg;

    localparam int c_FN_W = 32;

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_RUN  = 2'd1,
        ST_UCLR = 2'd2
    } tage_bank_state_e;

    // Counter values are zero-extended into c_FN_W bits; w is the real width.
    function automatic logic [c_FN_W-1:0] sat_inc(input logic [c_FN_W-1:0] v, input int w);
        logic [c_FN_W-1:0] maxv;
        maxv = (c_FN_W'(1) << w) - c_FN_W'(1);
        return (v >= maxv) ? maxv : v + c_FN_W'(1);
    endfunction

    function automatic logic [c_FN_W-1:0] sat_dec(input logic [c_FN_W-1:0] v, input int w);
        return ((v == '0) || (w == 0)) ? '0 : v - c_FN_W'(1);
    endfunction

    function automatic logic is_weak(input logic [c_FN_W-1:0] v, input int w);
        logic [c_FN_W-1:0] mid;
        mid = c_FN_W'(1) << (w - 1);
        return (v == mid) || (v == mid - c_FN_W'(1));
    endfunction

endpackage
`default_nettype wire

// File: rtl/tage_bank_entry_upd.sv
`default_nettype none
// ============================================================================
//  Module   : tage_bank_entry_upd
//  Brief    : Combinational next-entry computation (alloc / train / useful /
//             sweep clear mask), shared by the write and bypass paths.
//  Revision : 1.0 - initial release
// ============================================================================
module tage_bank_entry_upd
    import tage_pkg::*;
#(
    parameter int TAG_W = 9,
    parameter int CTR_W = 3,
    parameter int U_W   = 2,
    parameter int COL_W = 1
) (
    input  logic [CTR_W-1:0] i_ctr,
    input  logic [TAG_W-1:0] i_tag,
    input  logic [U_W-1:0]   i_u,
    input  logic             i_upd_en,
    input  logic             i_alloc,
    input  logic             i_provider,
    input  logic             i_taken,
    input  logic             i_u_inc,
    input  logic             i_u_dec,
    input  logic [TAG_W-1:0] i_upd_tag,
    input  logic             i_clr_en,
    input  logic [COL_W-1:0] i_clr_col,
    output logic [CTR_W-1:0] o_ctr,
    output logic [TAG_W-1:0] o_tag,
    output logic [U_W-1:0]   o_u
);

    localparam logic [CTR_W-1:0] c_MID = CTR_W'(1) << (CTR_W - 1);

    logic [U_W-1:0] w_u;
    logic [U_W-1:0] w_clr_mask;

    always_comb begin
        o_ctr = i_ctr;
        o_tag = i_tag;
        w_u   = i_u;
        if (i_upd_en) begin
            if (i_alloc) begin
                o_ctr = i_taken ? c_MID : c_MID - CTR_W'(1);
                o_tag = i_upd_tag;
                w_u   = '0;
            end else begin
                if (i_provider) begin
                    o_ctr = i_taken ? CTR_W'(sat_inc(c_FN_W'(i_ctr), CTR_W))
                                    : CTR_W'(sat_dec(c_FN_W'(i_ctr), CTR_W));
                end
                if (i_u_inc && !i_u_dec) begin
                    w_u = U_W'(sat_inc(c_FN_W'(i_u), U_W));
                end else if (i_u_dec && !i_u_inc) begin
                    w_u = U_W'(sat_dec(c_FN_W'(i_u), U_W));
                end
            end
        end
    end

    // The sweep clear lands after the update so a same-cycle increment cannot survive it.
    assign w_clr_mask = i_clr_en ? (U_W'(1) << i_clr_col) : '0;
    assign o_u        = w_u & ~w_clr_mask;

endmodule
`default_nettype wire

// File: rtl/tage_bank.sv
`default_nettype none
// ============================================================================
//  Module   : tage_bank
//  Brief    : TAGE tagged component bank with init sweep, write-first lookup
//             bypass and a paced background useful-bit clear.
//  Revision : 1.0 - initial release
// ============================================================================
module tage_bank
    import tage_pkg::*;
#(
    parameter int IDX_W     = 10,
    parameter int TAG_W     = 9,
    parameter int CTR_W     = 3,
    parameter int U_W       = 2,
    parameter int UCLR_LOG2 = 18
) (
    input  logic             clk_i,
    input  logic             rst_i,
    output logic             ready_o,
    input  logic             lkp_valid_i,
    input  logic [IDX_W-1:0] lkp_idx_i,
    input  logic [TAG_W-1:0] lkp_tag_i,
    output logic             lkp_valid_o,
    output logic             hit_o,
    output logic             pred_o,
    output logic             weak_o,
    output logic [U_W-1:0]   u_o,
    input  logic             upd_valid_i,
    input  logic [IDX_W-1:0] upd_idx_i,
    input  logic [TAG_W-1:0] upd_tag_i,
    input  logic             upd_taken_i,
    input  logic             upd_alloc_i,
    input  logic             upd_provider_i,
    input  logic             upd_u_inc_i,
    input  logic             upd_u_dec_i,
    output logic             uclr_busy_o
);

    localparam int               c_DEPTH    = 1 << IDX_W;
    localparam int               c_COL_W    = (U_W > 1) ? $clog2(U_W) : 1;
    localparam logic [c_COL_W-1:0] c_COL_RST = c_COL_W'(U_W - 1);

    tage_bank_state_e     r_state, w_state_nxt;
    logic [IDX_W-1:0]     r_ptr, w_ptr_nxt;
    logic [UCLR_LOG2-1:0] r_period, w_period_nxt;
    logic [c_COL_W-1:0]   r_col, w_col_nxt;

    logic [CTR_W-1:0] r_ctr_mem [c_DEPTH];
    logic [TAG_W-1:0] r_tag_mem [c_DEPTH];
    logic [U_W-1:0]   r_u_mem   [c_DEPTH];

    logic             r_lkp_valid, r_hit, r_pred, r_weak;
    logic [U_W-1:0]   r_u;

    logic             w_run, w_sweep;
    logic [U_W-1:0]   w_col_mask;
    logic [CTR_W-1:0] w_wr_ctr, w_byp_ctr;
    logic [TAG_W-1:0] w_wr_tag, w_byp_tag;
    logic [U_W-1:0]   w_wr_u, w_byp_u;

    assign w_run      = (r_state != ST_INIT);
    assign w_sweep    = (r_state == ST_UCLR);
    assign w_col_mask = U_W'(1) << r_col;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state  <= ST_INIT;
            r_ptr    <= '0;
            r_period <= '0;
            r_col    <= c_COL_RST;
        end else begin
            r_state  <= w_state_nxt;
            r_ptr    <= w_ptr_nxt;
            r_period <= w_period_nxt;
            r_col    <= w_col_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_ptr_nxt    = r_ptr;
        w_period_nxt = r_period;
        w_col_nxt    = r_col;
        case (r_state)
            ST_INIT: begin
                w_ptr_nxt = r_ptr + 1'b1;
                if (r_ptr == '1) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                w_period_nxt = r_period + 1'b1;
                if (r_period == '1) begin
                    w_state_nxt = ST_UCLR;
                    w_ptr_nxt   = '0;
                end
            end
            ST_UCLR: begin
                // Period keeps running; a wrap during the sweep is simply lost.
                w_period_nxt = r_period + 1'b1;
                w_ptr_nxt    = r_ptr + 1'b1;
                if (r_ptr == '1) begin
                    w_state_nxt = ST_RUN;
                    w_col_nxt   = (r_col == '0) ? c_COL_RST : r_col - 1'b1;
                end
            end
            default: begin
                w_state_nxt  = ST_INIT;
                w_ptr_nxt    = '0;
                w_period_nxt = '0;
            end
        endcase
    end

    tage_bank_entry_upd #(
        .TAG_W (TAG_W), .CTR_W (CTR_W), .U_W (U_W), .COL_W (c_COL_W)
    ) u_wr_upd (
        .i_ctr      (r_ctr_mem[upd_idx_i]),
        .i_tag      (r_tag_mem[upd_idx_i]),
        .i_u        (r_u_mem[upd_idx_i]),
        .i_upd_en   (1'b1),
        .i_alloc    (upd_alloc_i),
        .i_provider (upd_provider_i),
        .i_taken    (upd_taken_i),
        .i_u_inc    (upd_u_inc_i),
        .i_u_dec    (upd_u_dec_i),
        .i_upd_tag  (upd_tag_i),
        .i_clr_en   (w_sweep && (r_ptr == upd_idx_i)),
        .i_clr_col  (r_col),
        .o_ctr      (w_wr_ctr),
        .o_tag      (w_wr_tag),
        .o_u        (w_wr_u)
    );

    // Lookup sees the entry as it will look after this edge's writes.
    tage_bank_entry_upd #(
        .TAG_W (TAG_W), .CTR_W (CTR_W), .U_W (U_W), .COL_W (c_COL_W)
    ) u_byp_upd (
        .i_ctr      (r_ctr_mem[lkp_idx_i]),
        .i_tag      (r_tag_mem[lkp_idx_i]),
        .i_u        (r_u_mem[lkp_idx_i]),
        .i_upd_en   (upd_valid_i && w_run && (upd_idx_i == lkp_idx_i)),
        .i_alloc    (upd_alloc_i),
        .i_provider (upd_provider_i),
        .i_taken    (upd_taken_i),
        .i_u_inc    (upd_u_inc_i),
        .i_u_dec    (upd_u_dec_i),
        .i_upd_tag  (upd_tag_i),
        .i_clr_en   (w_sweep && (r_ptr == lkp_idx_i)),
        .i_clr_col  (r_col),
        .o_ctr      (w_byp_ctr),
        .o_tag      (w_byp_tag),
        .o_u        (w_byp_u)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            if (r_state == ST_INIT) begin
                r_ctr_mem[r_ptr] <= '0;
                r_tag_mem[r_ptr] <= '0;
                r_u_mem[r_ptr]   <= '0;
            end else begin
                if (w_sweep) begin
                    r_u_mem[r_ptr] <= r_u_mem[r_ptr] & ~w_col_mask;
                end
                if (upd_valid_i) begin
                    r_ctr_mem[upd_idx_i] <= w_wr_ctr;
                    r_tag_mem[upd_idx_i] <= w_wr_tag;
                    r_u_mem[upd_idx_i]   <= w_wr_u;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_lkp_valid <= 1'b0;
            r_hit       <= 1'b0;
            r_pred      <= 1'b0;
            r_weak      <= 1'b0;
            r_u         <= '0;
        end else if (lkp_valid_i) begin
            r_lkp_valid <= 1'b1;
            if (w_run) begin
                r_hit  <= (w_byp_tag == lkp_tag_i);
                r_pred <= w_byp_ctr[CTR_W-1];
                r_weak <= is_weak(c_FN_W'(w_byp_ctr), CTR_W) && (w_byp_u == '0);
                r_u    <= w_byp_u;
            end else begin
                r_hit  <= 1'b0;
                r_pred <= 1'b0;
                r_weak <= 1'b0;
                r_u    <= '0;
            end
        end else begin
            r_lkp_valid <= 1'b0;
        end
    end

    assign ready_o     = w_run;
    assign uclr_busy_o = w_sweep;
    assign lkp_valid_o = r_lkp_valid;
    assign hit_o       = r_hit;
    assign pred_o      = r_pred;
    assign weak_o      = r_weak;
    assign u_o         = r_u;

endmodule
`default_nettype wire

// File: tb/tb_tage_bank.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tage_bank
//  Brief    : Self-checking bench for tage_bank against an array-based model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_tage_bank;

    localparam int IDX_W     = 4;
    localparam int TAG_W     = 9;
    localparam int CTR_W     = 3;
    localparam int U_W       = 2;
    localparam int UCLR_LOG2 = 12;
    localparam int DEPTH     = 1 << IDX_W;
    localparam int PER       = 1 << UCLR_LOG2;
    localparam int MID       = 1 << (CTR_W - 1);
    localparam int CMAX      = (1 << CTR_W) - 1;
    localparam int UMAX      = (1 << U_W) - 1;
    localparam int OW        = U_W + 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             ready_o;
    logic             lkp_valid = 1'b0;
    logic [IDX_W-1:0] lkp_idx = '0;
    logic [TAG_W-1:0] lkp_tag = '0;
    logic             lkp_valid_o, hit_o, pred_o, weak_o;
    logic [U_W-1:0]   u_o;
    logic             upd_valid = 1'b0;
    logic [IDX_W-1:0] upd_idx = '0;
    logic [TAG_W-1:0] upd_tag = '0;
    logic             upd_taken = 1'b0, upd_alloc = 1'b0, upd_provider = 1'b0;
    logic             upd_u_inc = 1'b0, upd_u_dec = 1'b0;
    logic             uclr_busy_o;

    int checks = 0;
    int errors = 0;

    int           m_ctr [DEPTH];
    int           m_tag [DEPTH];
    int           m_u   [DEPTH];
    bit           m_ready = 1'b0;
    int           init_cnt = 0;
    int           n = 0;
    logic [OW-1:0] e_lk = '0;
    bit           e_busy = 1'b0;

    wire [OW-1:0] obs = {lkp_valid_o, hit_o, pred_o, weak_o, u_o};

    tage_bank #(
        .IDX_W (IDX_W), .TAG_W (TAG_W), .CTR_W (CTR_W), .U_W (U_W), .UCLR_LOG2 (UCLR_LOG2)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .ready_o        (ready_o),
        .lkp_valid_i    (lkp_valid),
        .lkp_idx_i      (lkp_idx),
        .lkp_tag_i      (lkp_tag),
        .lkp_valid_o    (lkp_valid_o),
        .hit_o          (hit_o),
        .pred_o         (pred_o),
        .weak_o         (weak_o),
        .u_o            (u_o),
        .upd_valid_i    (upd_valid),
        .upd_idx_i      (upd_idx),
        .upd_tag_i      (upd_tag),
        .upd_taken_i    (upd_taken),
        .upd_alloc_i    (upd_alloc),
        .upd_provider_i (upd_provider),
        .upd_u_inc_i    (upd_u_inc),
        .upd_u_dec_i    (upd_u_dec),
        .uclr_busy_o    (uclr_busy_o)
    );

    always #5 clk = ~clk;

    // Reference: n counts edges since ready; sweep k clears entry j on edge k*PER+1+j.
    task automatic model_edge();
        bit was_ready;
        int j, k, col, li;
        if (rst) begin
            m_ready  = 1'b0;
            init_cnt = 0;
            n        = 0;
            e_lk     = '0;
            for (int i = 0; i < DEPTH; i++) begin
                m_ctr[i] = 0; m_tag[i] = 0; m_u[i] = 0;
            end
        end else begin
            was_ready = m_ready;
            if (!m_ready) begin
                init_cnt++;
                if (init_cnt == DEPTH) m_ready = 1'b1;
            end else begin
                n++;
                if (upd_valid) begin
                    j = int'(upd_idx);
                    if (upd_alloc) begin
                        m_ctr[j] = upd_taken ? MID : MID - 1;
                        m_tag[j] = int'(upd_tag);
                        m_u[j]   = 0;
                    end else begin
                        if (upd_provider) begin
                            if (upd_taken) m_ctr[j] = (m_ctr[j] < CMAX) ? m_ctr[j] + 1 : CMAX;
                            else           m_ctr[j] = (m_ctr[j] > 0) ? m_ctr[j] - 1 : 0;
                        end
                        if (upd_u_inc && !upd_u_dec && m_u[j] < UMAX) m_u[j]++;
                        if (upd_u_dec && !upd_u_inc && m_u[j] > 0) m_u[j]--;
                    end
                end
                k = (n - 1) / PER;
                j = (n - 1) % PER;
                if (k >= 1 && j < DEPTH) begin
                    col = (U_W - 1) - ((k - 1) % U_W);
                    m_u[j] = m_u[j] & ~(1 << col);
                end
            end
            if (lkp_valid) begin
                li = int'(lkp_idx);
                if (!was_ready) e_lk = {1'b1, {(OW-1){1'b0}}};
                else e_lk = {1'b1, m_tag[li] == int'(lkp_tag), m_ctr[li] >= MID,
                             (m_ctr[li] == MID || m_ctr[li] == MID - 1) && m_u[li] == 0,
                             U_W'(m_u[li])};
            end else begin
                e_lk[OW-1] = 1'b0;
            end
        end
        e_busy = m_ready && n >= PER && (n % PER) < DEPTH;
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic upd_cycle(input int idx, input int tag, input bit taken, input bit alloc,
                             input bit prov, input bit inc, input bit dec);
        upd_valid = 1'b1; upd_idx = IDX_W'(idx); upd_tag = TAG_W'(tag);
        upd_taken = taken; upd_alloc = alloc; upd_provider = prov;
        upd_u_inc = inc; upd_u_dec = dec;
        cyc();
        upd_valid = 1'b0; upd_alloc = 1'b0; upd_provider = 1'b0;
        upd_u_inc = 1'b0; upd_u_dec = 1'b0;
    endtask

    task automatic lkp_cycle(input int idx, input int tag);
        lkp_valid = 1'b1; lkp_idx = IDX_W'(idx); lkp_tag = TAG_W'(tag);
        cyc();
        lkp_valid = 1'b0;
    endtask

    task automatic set_all_u3();
        for (int i = 0; i < DEPTH; i++)
            for (int r = 0; r < 3; r++) upd_cycle(i, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic wait_n(input int target);
        for (int t = 0; t < 3 * PER && n != target; t++) cyc();
    endtask

    task automatic test_reset();
        int cnt;
        rst = 1'b1;
        cyc(); cyc();
        checks++;
        if ({ready_o, uclr_busy_o, obs} !== '0) begin
            errors++; $display("FAIL reset_outputs: got %b expected 0", {ready_o, uclr_busy_o, obs});
        end
        rst = 1'b0;
        lkp_cycle(3, 0);
        checks++;
        if (obs !== 6'b100000) begin
            errors++; $display("FAIL init_lookup: got %b expected 100000", obs);
        end
        cnt = 1;
        while (!ready_o && cnt < 100) begin cyc(); cnt++; end
        checks++;
        if (cnt != DEPTH) begin
            errors++; $display("FAIL init_length: got %0d cycles expected %0d", cnt, DEPTH);
        end
        lkp_cycle(5, 0);
        checks++;
        if (obs !== 6'b110000) begin
            errors++; $display("FAIL post_init_lookup: got %b expected 110000", obs);
        end
    endtask

    task automatic test_alloc();
        upd_cycle(7, 'h1A5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        lkp_cycle(7, 'h1A5);
        checks++;
        if (obs !== 6'b111100) begin
            errors++; $display("FAIL alloc_hit: got %b expected 111100", obs);
        end
        lkp_cycle(7, 'h1A4);
        checks++;
        if (obs !== 6'b101100) begin
            errors++; $display("FAIL alloc_miss: got %b expected 101100", obs);
        end
        cyc();
        checks++;
        if (obs !== 6'b001100) begin
            errors++; $display("FAIL lookup_hold: got %b expected 001100", obs);
        end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 5; i++) upd_cycle(7, 0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        lkp_cycle(7, 'h1A5);
        checks++;
        if (obs !== 6'b111000) begin
            errors++; $display("FAIL ctr_sat_high: got %b expected 111000", obs);
        end
        for (int i = 0; i < 8; i++) upd_cycle(7, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        lkp_cycle(7, 'h1A5);
        checks++;
        if (obs !== 6'b110000) begin
            errors++; $display("FAIL ctr_sat_low: got %b expected 110000", obs);
        end
        for (int i = 0; i < 4; i++) upd_cycle(7, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        lkp_cycle(7, 'h1A5);
        checks++;
        if (obs !== 6'b110011) begin
            errors++; $display("FAIL u_sat_high: got %b expected 110011", obs);
        end
        upd_cycle(7, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        lkp_cycle(7, 'h1A5);
        checks++;
        if (obs !== 6'b110011) begin
            errors++; $display("FAIL u_inc_dec: got %b expected 110011", obs);
        end
        upd_cycle(7, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        lkp_cycle(7, 'h1A5);
        checks++;
        if (obs !== 6'b110010) begin
            errors++; $display("FAIL u_dec: got %b expected 110010", obs);
        end
    endtask

    task automatic test_bypass();
        lkp_valid = 1'b1; lkp_idx = 4'd9; lkp_tag = 9'h0C3;
        upd_cycle(9, 'h0C3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        lkp_valid = 1'b0;
        checks++;
        if (obs !== 6'b110100) begin
            errors++; $display("FAIL bypass_alloc: got %b expected 110100", obs);
        end
        lkp_valid = 1'b1;
        upd_cycle(9, 0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        lkp_valid = 1'b0;
        checks++;
        if (obs !== 6'b111100) begin
            errors++; $display("FAIL bypass_train: got %b expected 111100", obs);
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 300; it++) begin
            upd_valid    = 1'($urandom_range(0, 1));
            upd_idx      = IDX_W'($urandom_range(0, DEPTH - 1));
            upd_tag      = TAG_W'($urandom_range(0, 3));
            upd_taken    = 1'($urandom_range(0, 1));
            upd_alloc    = ($urandom_range(0, 4) == 0);
            upd_provider = 1'($urandom_range(0, 1));
            upd_u_inc    = 1'($urandom_range(0, 1));
            upd_u_dec    = 1'($urandom_range(0, 1));
            lkp_valid    = ($urandom_range(0, 9) < 7);
            lkp_idx      = ($urandom_range(0, 2) == 0) ? upd_idx : IDX_W'($urandom_range(0, DEPTH - 1));
            lkp_tag      = TAG_W'($urandom_range(0, 3));
            cyc();
            checks++;
            if (obs !== e_lk || uclr_busy_o !== e_busy) begin
                errors++;
                $display("FAIL random_%0d: got %b/%b expected %b/%b", it, obs, uclr_busy_o, e_lk, e_busy);
            end
        end
        upd_valid = 1'b0; upd_alloc = 1'b0; upd_provider = 1'b0;
        upd_u_inc = 1'b0; upd_u_dec = 1'b0; lkp_valid = 1'b0;
    endtask

    task automatic test_useful_clear();
        int busy_cnt;
        set_all_u3();
        wait_n(PER - 1);
        busy_cnt = 0;
        for (int t = 0; t < 24; t++) begin
            if (n == PER + 5) upd_cycle(5, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
            else cyc();
            if (uclr_busy_o) busy_cnt++;
            checks++;
            if (uclr_busy_o !== e_busy) begin
                errors++; $display("FAIL sweep1_busy_t%0d: got %b expected %b", t, uclr_busy_o, e_busy);
            end
        end
        checks++;
        if (busy_cnt != DEPTH) begin
            errors++; $display("FAIL sweep1_busy_len: got %0d expected %0d", busy_cnt, DEPTH);
        end
        for (int i = 0; i < DEPTH; i++) begin
            lkp_cycle(i, $urandom_range(0, 3));
            checks++;
            if (obs !== e_lk || u_o !== 2'd1) begin
                errors++; $display("FAIL sweep1_u_idx%0d: got %b expected %b (u=1)", i, obs, e_lk);
            end
        end
        wait_n(2 * PER + DEPTH + 1);
        for (int i = 0; i < DEPTH; i++) begin
            lkp_cycle(i, $urandom_range(0, 3));
            checks++;
            if (obs !== e_lk || u_o !== 2'd0) begin
                errors++; $display("FAIL sweep2_u_idx%0d: got %b expected %b (u=0)", i, obs, e_lk);
            end
        end
    endtask

    task automatic test_reset_mid_uclr();
        int cnt;
        wait_n(3 * PER + DEPTH + 1);
        set_all_u3();
        wait_n(4 * PER + 8);
        checks++;
        if (uclr_busy_o !== 1'b1 || n != 4 * PER + 8) begin
            errors++; $display("FAIL mid_sweep_reach: busy %b n %0d expected busy 1", uclr_busy_o, n);
        end
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        checks++;
        if ({ready_o, uclr_busy_o, obs} !== '0) begin
            errors++; $display("FAIL mid_sweep_reset: got %b expected 0", {ready_o, uclr_busy_o, obs});
        end
        cnt = 0;
        while (!ready_o && cnt < 100) begin cyc(); cnt++; end
        checks++;
        if (cnt != DEPTH) begin
            errors++; $display("FAIL reinit_length: got %0d cycles expected %0d", cnt, DEPTH);
        end
        for (int i = 0; i < DEPTH; i++) begin
            lkp_cycle(i, 0);
            checks++;
            if (obs !== 6'b110000) begin
                errors++; $display("FAIL reinit_idx%0d: got %b expected 110000", i, obs);
            end
        end
        for (int r = 0; r < 3; r++) upd_cycle(2, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        wait_n(PER + DEPTH + 1);
        lkp_cycle(2, 0);
        checks++;
        if (obs !== 6'b110001 || obs !== e_lk) begin
            errors++; $display("FAIL col_after_reset: got %b expected 110001", obs);
        end
    endtask

    initial begin
        test_reset();
        test_alloc();
        test_saturation();
        test_bypass();
        test_random();
        test_useful_clear();
        test_reset_mid_uclr();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
